serial_compl_arbiter: RTL and testbench



---
 rtl/serial_compl_arbiter_if.sv | 30 +++
 rtl/serial_compl_arbiter.sv | 112 +++++++++++
 tb/tb_serial_compl_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_compl_arbiter_if.sv
// Word-level client and serial-datapath signals of serial_compl_arbiter.
// The arbiter takes the slave modport; clients and the complementer sit on the master side.
interface serial_compl_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic             res_valid;
    logic             res_id;
    logic [WIDTH-1:0] res_data;
    logic             res_ack;
    logic             busy;
    logic             ser_rst;
    logic             ser_in;
    logic             ser_out;

    modport master (
        output req0, req1, data0, data1, res_ack, ser_out,
        input  gnt0, gnt1, res_valid, res_id, res_data, busy, ser_rst, ser_in
    );

    modport slave (
        input  req0, req1, data0, data1, res_ack, ser_out,
        output gnt0, gnt1, res_valid, res_id, res_data, busy, ser_rst, ser_in
    );
endinterface

// File: rtl/serial_compl_arbiter.sv
// Arbitrates two word requesters onto one bit-serial two's-complementer and returns results.
// Define SERIAL_ARB_RR_EN for round-robin arbitration; fixed priority (req0 wins) otherwise.
module serial_compl_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input logic                   clk,
    input logic                   rst,
    serial_compl_arbiter_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StClr, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             id_q, id_d;
    logic             win1;
    logic             gnt0, gnt1, ser_in, clr;

`ifdef SERIAL_ARB_RR_EN
    logic last_q, last_d;

    // On contention, requester 1 wins only if requester 0 was granted last.
    assign win1 = bus.req1 & (~bus.req0 | ~last_q);
`else
    assign win1 = bus.req1 & ~bus.req0;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        ser_in  = 1'b0;
        clr     = 1'b0;
`ifdef SERIAL_ARB_RR_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.req0 | bus.req1) begin
                    gnt0    = ~win1;
                    gnt1    = win1;
                    id_d    = win1;
                    shreg_d = win1 ? bus.data1 : bus.data0;
`ifdef SERIAL_ARB_RR_EN
                    last_d  = win1;
`endif
                    state_d = StClr;
                end
            end
            StClr: begin
                clr     = 1'b1;
                cnt_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                // Complementer output is Mealy, so it belongs to the bit presented this cycle.
                ser_in  = shreg_q[0];
                shreg_d = shreg_q >> 1;
                res_d   = {bus.ser_out, res_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.res_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
`ifdef SERIAL_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
`ifdef SERIAL_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // Outputs are forced to their idle values while reset is asserted.
    assign bus.gnt0      = gnt0 & ~rst;
    assign bus.gnt1      = gnt1 & ~rst;
    assign bus.ser_in    = ser_in & ~rst;
    assign bus.ser_rst   = clr | rst;
    assign bus.res_valid = (state_q == StDone) & ~rst;
    assign bus.busy      = (state_q != StIdle) & ~rst;
    assign bus.res_id    = id_q;
    assign bus.res_data  = res_q;
endmodule

// File: tb/tb_serial_compl_arbiter.sv
// Randomized self-checking bench for serial_compl_arbiter with a behavioural complementer.
module tb_serial_compl_arbiter;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    logic seen = 1'b0;
    logic last_id = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    serial_compl_arbiter_if #(.WIDTH(W)) ifc ();

    serial_compl_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // Serial complementer: copy bits up to and including the first 1, invert the rest.
    always @(posedge clk) begin
        if (ifc.ser_rst) seen <= 1'b0;
        else if (ifc.ser_in) seen <= 1'b1;
    end
    assign ifc.ser_out = ifc.ser_in ^ seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic pick(input logic r0, input logic r1);
        if (r0 && r1) begin
`ifdef SERIAL_ARB_RR_EN
            return ~last_id;
`else
            return 1'b0;
`endif
        end
        return r1;
    endfunction

    // Waits for a grant and follows the word through CLR, SHIFT and DONE to the ack.
    task automatic serve_one(input int ack_delay, input bit hold);
        int           waited;
        logic         w;
        logic [W-1:0] d;
        logic [W-1:0] exp;
        waited = 0;
        #1;
        while (!(ifc.gnt0 || ifc.gnt1) && waited < 50) begin
            cyc();
            #1;
            waited++;
        end
        if (!(ifc.gnt0 || ifc.gnt1)) begin
            check("grant_timeout", {31'b0, ifc.gnt0 | ifc.gnt1}, 32'd1);
            ifc.req0 = 1'b0;
            ifc.req1 = 1'b0;
            return;
        end
        w   = pick(ifc.req0, ifc.req1);
        check("gnt0", ifc.gnt0, !w);
        check("gnt1", ifc.gnt1, w);
        d   = w ? ifc.data1 : ifc.data0;
        exp = W'((1 << W) - int'(d));
        last_id = w;
        cyc();
        if (!hold) begin
            if (w) ifc.req1 = 1'b0;
            else ifc.req0 = 1'b0;
        end
        #1;
        check("clr_ser_rst", ifc.ser_rst, 1);
        check("clr_busy", ifc.busy, 1);
        check("clr_no_gnt", ifc.gnt0 | ifc.gnt1, 0);
        for (int i = 0; i < W; i++) begin
            cyc();
            #1;
            check("shift_ser_rst", ifc.ser_rst, 0);
            check("shift_ser_in", ifc.ser_in, d[i]);
            check("shift_valid", ifc.res_valid, 0);
        end
        cyc();
        #1;
        check("res_valid", ifc.res_valid, 1);
        check("res_data", ifc.res_data, exp);
        check("res_id", ifc.res_id, w);
        for (int k = 0; k < ack_delay; k++) begin
            cyc();
            #1;
            check("hold_valid", ifc.res_valid, 1);
            check("hold_data", ifc.res_data, exp);
            check("hold_id", ifc.res_id, w);
            check("hold_no_gnt", ifc.gnt0 | ifc.gnt1, 0);
        end
        ifc.res_ack = 1'b1;
        cyc();
        ifc.res_ack = 1'b0;
        #1;
        check("ack_busy", ifc.busy, 0);
        check("ack_valid", ifc.res_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] r;
        rst         = 1'b1;
        ifc.req0    = 1'b1;
        ifc.req1    = 1'b0;
        ifc.data0   = 8'h0C;
        ifc.data1   = 8'h00;
        ifc.res_ack = 1'b0;
        cyc();
        cyc();
        #1;
        check("rst_ser_rst", ifc.ser_rst, 1);
        check("rst_gnt0", ifc.gnt0, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_valid", ifc.res_valid, 0);
        check("rst_ser_in", ifc.ser_in, 0);
        ifc.req0 = 1'b0;
        rst      = 1'b0;
        cyc();
        #1;
        check("idle_busy", ifc.busy, 0);
        check("idle_res_data", ifc.res_data, 0);
        check("idle_res_id", ifc.res_id, 0);
        check("idle_ser_rst", ifc.ser_rst, 0);
        check("idle_gnt", ifc.gnt0 | ifc.gnt1, 0);

        // Stray ack with nothing valid.
        ifc.res_ack = 1'b1;
        cyc();
        ifc.res_ack = 1'b0;
        #1;
        check("stray_ack_busy", ifc.busy, 0);
        check("stray_ack_valid", ifc.res_valid, 0);

        // 0x0C -> 0xF4, serial bits 0,0,1,1,0,0,0,0.
        ifc.req0  = 1'b1;
        ifc.data0 = 8'h0C;
        serve_one(0, 1'b0);

        // Boundary operands 0x00 and 0x80.
        ifc.req1  = 1'b1;
        ifc.data1 = 8'h00;
        serve_one(0, 1'b0);
        ifc.req0  = 1'b1;
        ifc.data0 = 8'h80;
        serve_one(0, 1'b0);

        // Contention with both requests held throughout.
        ifc.req0  = 1'b1;
        ifc.data0 = 8'h01;
        ifc.req1  = 1'b1;
        ifc.data1 = 8'h05;
        for (int n = 0; n < 3; n++) serve_one(0, 1'b1);
        ifc.req0 = 1'b0;
        ifc.req1 = 1'b0;

        // Long ack stall with the other requester pending.
        ifc.req0  = 1'b1;
        ifc.data0 = 8'h33;
        ifc.req1  = 1'b1;
        ifc.data1 = 8'hA7;
        serve_one(20, 1'b0);
        serve_one(0, 1'b0);

        // Reset during SHIFT at G+4, then regrant of the held request.
        ifc.req0  = 1'b1;
        ifc.data0 = 8'h5A;
        #1;
        check("pre_rst_gnt0", ifc.gnt0, 1);
        for (int n = 0; n < 4; n++) cyc();
        rst = 1'b1;
        #1;
        check("mid_rst_ser_rst", ifc.ser_rst, 1);
        check("mid_rst_gnt", ifc.gnt0 | ifc.gnt1, 0);
        cyc();
        rst     = 1'b0;
        last_id = 1'b1;
        #1;
        check("post_rst_busy", ifc.busy, 0);
        check("post_rst_valid", ifc.res_valid, 0);
        check("post_rst_regrant", ifc.gnt0, 1);
        serve_one(0, 1'b0);

        // Random traffic.
        for (int n = 0; n < 25; n++) begin
            r         = 2'($urandom_range(1, 3));
            ifc.req0  = r[0];
            ifc.req1  = r[1];
            ifc.data0 = W'($urandom);
            ifc.data1 = W'($urandom);
            for (int s = 0; s < 2 && (ifc.req0 || ifc.req1); s++) begin
                serve_one(int'($urandom_range(0, 3)), 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
